// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e    : fetch FSM encoding
//   WORD_BYTES       : bytes per instruction word (PC increment, alignment)
//   IR_RESET_DEFAULT : default instruction register reset value
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] IR_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus (req/ack handshake).
//   mem_req   : read request, held until ack (or abort)
//   mem_addr  : word address, stable while mem_req=1
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : single-cycle acknowledge
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, input  mem_rdata, input  mem_ack);
  modport slave  (input  mem_req, input  mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_timer.sv
// Fetch timeout counter (built only with FETCH_TIMEOUT_EN).
//   CLK, RST_n : clock, async active-low reset
//   clr        : zero the count (held while the fetch unit is idle)
//   en         : a BUSY cycle ended without ack
//   expire     : this enabled cycle is the LIMIT-th one without ack
module fetch_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  // Fires on the edge that would bring the count to LIMIT.
  assign expire = en && (cnt == 8'(LIMIT - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage of the multicycle CPU.
// Captures the PC on fetch_start, reads one word from instruction memory
// over a req/ack bus, loads it into IR and pulses ir_valid; also provides
// the registered PC+4.
//   CLK, RST_n  : clock, async active-low reset
//   pc_addr     : PC, sampled on the fetch_start edge
//   fetch_start : fetch request (honoured in IDLE only)
//   flush       : abort an in-flight fetch
//   mem         : instruction memory bus (master side)
//   ir/ir_valid : instruction register and its one-cycle load pulse
//   pc_plus4    : latched address + 4
//   busy        : FSM not in IDLE
//   fetch_err   : one-cycle pulse on misaligned PC (or timeout)
// Optional: `define FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT_CYCLES
// request cycles without ack.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [DATA_W-1:0] IR_RESET       = DATA_W'(IR_RESET_DEFAULT),
  parameter int unsigned       TIMEOUT_CYCLES = 15
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               fetch_start,
  input  logic               flush,
  instr_fetch_unit_if.master mem,
  output logic [DATA_W-1:0]  ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               busy,
  output logic               fetch_err
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  fetch_state_e state;
  logic         tmr_expire;

`ifdef FETCH_TIMEOUT_EN
  // Counts only BUSY cycles that end without ack or flush; idle clears it.
  fetch_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .clr    (state == IDLE),
    .en     (state == BUSY && !mem.mem_ack && !flush),
    .expire (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state        <= IDLE;
      ir           <= IR_RESET;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      pc_plus4     <= '0;
      ir_valid     <= 1'b0;
      fetch_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && fetch_start) begin
            busy <= 1'b1;
            if (pc_addr[1:0] == 2'b00) begin
              mem.mem_addr <= pc_addr;
              pc_plus4     <= pc_addr + ADDR_W'(WORD_BYTES);
              mem.mem_req  <= 1'b1;
              state        <= BUSY;
            end else begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end
          end
        end
        BUSY: begin
          // flush beats ack; ack beats timeout expiry.
          if (flush) begin
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (mem.mem_ack) begin
            ir          <= mem.mem_rdata;
            ir_valid    <= 1'b1;
            mem.mem_req <= 1'b0;
            state       <= DONE;
          end else if (tmr_expire) begin
            fetch_err   <= 1'b1;
            mem.mem_req <= 1'b0;
            state       <= ERR;
          end
        end
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register in the multicycle CPU.
- On a fetch request, captures the current PC address and issues a word read to instruction memory over a req/ack handshake.
- Loads the returned word into the instruction register (IR) and pulses a valid flag to the control unit.
- Also produces the registered PC+4 for the next-PC mux.

Parameters:
- ADDR_W, 32, width of PC/memory address.
- DATA_W, 32, instruction word width.
- IR_RESET, 32'h0000_0000, IR value after reset.
- TIMEOUT_CYCLES, 15, max req cycles without ack (used only with FETCH_TIMEOUT_EN); legal range 1..255.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_n  in  1  asynchronous active-low reset.
- pc_addr  in  ADDR_W  current PC output; sampled at the posedge where fetch_start=1.
- fetch_start  in  1  fetch request from the control unit; honoured only in IDLE.
- flush  in  1  abort an in-flight fetch.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1.
- mem_ack  in  1  memory acknowledge; single-cycle pulse.
- ir  out  DATA_W  instruction register.
- ir_valid  out  1  one-cycle pulse when ir has just been loaded.
- pc_plus4  out  ADDR_W  latched address + 4.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle pulse on misaligned address (or timeout, with the option).

Behaviour:
- Reset (async, RST_n=0):
  - state=IDLE; ir=IR_RESET; mem_req=0; mem_addr=0; pc_plus4=0.
  - ir_valid=0; fetch_err=0; busy=0; timeout counter=0.
- States: IDLE, BUSY, DONE, ERR.
- IDLE:
  - On fetch_start=1 with pc_addr[1:0]==0: latch mem_addr=pc_addr and pc_plus4=pc_addr+4 (mod 2^ADDR_W, so 0xFFFF_FFFC -> 0x0000_0000); go to BUSY.
  - On fetch_start=1 with pc_addr[1:0]!=0: go to ERR; no memory request; ir unchanged.
- BUSY:
  - mem_req=1 (registered output, asserted the cycle after the start edge).
  - At a posedge with mem_ack=1: ir<=mem_rdata; go to DONE.
  - mem_req is low in the following cycle.
- DONE: ir_valid=1 for exactly this cycle; next state IDLE.
- ERR: fetch_err=1 for exactly this cycle; next state IDLE.
- Latency: start edge to ir_valid is 2 cycles when ack arrives in the first req cycle, plus 1 per extra wait cycle. Back-to-back fetch throughput is 1 per 3 cycles minimum.
- fetch_start outside IDLE is ignored; no queueing.
- flush:
  - In BUSY: flush takes priority over a same-edge mem_ack. Go to IDLE, mem_req drops next cycle, ir unchanged, no ir_valid.
  - In IDLE: flush takes priority over fetch_start.
  - In DONE or ERR: no effect.
- mem_ack outside BUSY is ignored.
- Reset asserted mid-fetch drops mem_req immediately (asynchronously); the fetch is lost.
- ir holds its value at all times except the BUSY->DONE load.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack, go to ERR (fetch_err pulse) and drop mem_req.
  - ack on the same edge as expiry wins: the fetch completes normally.
- Undefined: no counter logic; BUSY waits indefinitely for mem_ack.

Decomposition:
- Package fetch_pkg:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2, ERR=2'd3);
  - WORD_BYTES=4;
  - default IR_RESET constant.
- One sub-module, fetch_timer: the timeout counter with clear, enable and expire outputs. Instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
1. Reset, then pc_addr=0x0000_0010 with fetch_start, ack with rdata=0x2001_0005 in first req cycle -> mem_addr=0x10; ir=0x2001_0005 and ir_valid pulse 2 cycles after start; pc_plus4=0x14.
2. Start at 0x40, ack delayed 3 cycles -> mem_req high 4 cycles with mem_addr stable at 0x40; ir_valid at cycle 5; fetch_start pulses during BUSY ignored.
3. pc_addr=0x0000_0022 with fetch_start -> no mem_req; fetch_err pulse 1 cycle after start; ir unchanged.
4. Start at 0x80, then flush and mem_ack on the same edge -> ir unchanged, no ir_valid, busy low next cycle; a fresh fetch from 0x84 then succeeds.
5. pc_addr=0xFFFF_FFFC -> pc_plus4=0x0000_0000; RST_n pulsed low mid-BUSY -> mem_req, busy and ir return to reset values immediately.
6. With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then fetch_err pulse; with ack on the expiry edge -> normal ir load, no error.
